alu_decode: RTL

ALU_DECODE -- requirements
Module: alu_decode

---
 rtl/alu_decode_pkg.sv | 39 +++
 rtl/alu_decode_regfile.sv | 34 +++
 rtl/alu_decode.sv | 101 ++++++++++
 3 files changed

// File: rtl/alu_decode_pkg.sv
// Shared decode parameters: ALU opcodes, major-op encodings and instruction
// field positions. The ALU imports the same package so both ends agree.
package alu_decode_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } alu_op_e;

  localparam logic [3:0] MAJOR_ADD = 4'h0;
  localparam logic [3:0] MAJOR_SUB = 4'h1;
  localparam logic [3:0] MAJOR_MUL = 4'h2;

  localparam int MAJOR_HI = 31;
  localparam int MAJOR_LO = 28;
  localparam int RD_HI    = 27;
  localparam int RD_LO    = 23;
  localparam int RS1_HI   = 22;
  localparam int RS1_LO   = 18;
  localparam int RS2_HI   = 17;
  localparam int RS2_LO   = 13;

  // Majors above MAJOR_MUL are undefined.
  function automatic logic major_is_legal(input logic [3:0] major);
    return (major <= MAJOR_MUL);
  endfunction

  function automatic alu_op_e major_to_op(input logic [3:0] major);
    alu_op_e op;
    case (major)
      MAJOR_SUB: op = OP_SUB;
      MAJOR_MUL: op = OP_MUL;
      default:   op = OP_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_decode_regfile.sv
// 32 x 32-bit register file: two asynchronous read ports, one synchronous
// write port. R0 is never written and always reads as zero.
module regfile (
  input  logic        clock,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  output logic [31:0] rdata_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_b
);

  logic [31:0] mem [0:31];

  // Write port; R0 writes dropped, whole array cleared on reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr != 5'd0)) begin
      mem[waddr] <= wdata;
    end
  end

  // Read ports return pre-write contents on a same-cycle write.
  always_comb begin
    rdata_a = (raddr_a == 5'd0) ? 32'd0 : mem[raddr_a];
    rdata_b = (raddr_b == 5'd0) ? 32'd0 : mem[raddr_b];
  end

endmodule

// File: rtl/alu_decode.sv
// Instruction decode / issue stage: splits the instruction word, reads
// operands from the register file and holds a one-deep issue bundle with a
// valid/ready handshake toward the ALU.
// Optional build macro DECODE_BYPASS_EN: forwards a same-cycle write-back
// value into the operands. Undefined, operands see the pre-write value.
module alu_decode
  import alu_decode_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_opcode,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [4:0]  out_rd,
  output logic        illegal
);

  logic [3:0]  major;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] rf_a;
  logic [31:0] rf_b;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        accept;
  logic        unused_bits;

  assign major       = in_instr[MAJOR_HI:MAJOR_LO];
  assign rd          = in_instr[RD_HI:RD_LO];
  assign rs1         = in_instr[RS1_HI:RS1_LO];
  assign rs2         = in_instr[RS2_HI:RS2_LO];
  assign unused_bits = ^in_instr[12:0];

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  regfile u_regfile (
    .clock   (clock),
    .reset   (reset),
    .we      (wb_en),
    .waddr   (wb_rd),
    .wdata   (wb_data),
    .raddr_a (rs1),
    .rdata_a (rf_a),
    .raddr_b (rs2),
    .rdata_b (rf_b)
  );

`ifdef DECODE_BYPASS_EN
  // Forward a write landing on this edge so the bundle sees the new value.
  always_comb begin
    op_a = (wb_en && (wb_rd == rs1) && (rs1 != 5'd0)) ? wb_data : rf_a;
    op_b = (wb_en && (wb_rd == rs2) && (rs2 != 5'd0)) ? wb_data : rf_b;
  end
`else
  // No forwarding: software keeps producer and consumer apart.
  always_comb begin
    op_a = rf_a;
    op_b = rf_b;
  end
`endif

  // Issue register: loads on accept, drains on consume, holds while stalled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      illegal    <= 1'b0;
      out_opcode <= OP_ADD;
      out_a      <= '0;
      out_b      <= '0;
      out_rd     <= '0;
    end else begin
      illegal <= 1'b0;
      if (accept) begin
        if (major_is_legal(major)) begin
          out_valid  <= 1'b1;
          out_opcode <= major_to_op(major);
          out_a      <= op_a;
          out_b      <= op_b;
          out_rd     <= rd;
        end else begin
          // Undefined major is consumed without issuing a bundle.
          out_valid <= 1'b0;
          illegal   <= 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
